// File: rtl/ysyx_25070198_sbus_sram.sv
// ----------------------------------------------------------------------------
// ysyx_25070198_sbus_sram
//
// SimpleBus slave data memory for simulation, sitting behind the LSU port.
// One request is handled at a time. The request is latched on acceptance.
// A registered one-cycle response then follows after a fixed latency, or
// after a pseudo-random latency.
//
// Optional feature macro: SBUS_RAND_DELAY_EN
//   defined   -> latency 1..4 drawn from an 8-bit LFSR (FIXED_LAT unused)
//   undefined -> latency is FIXED_LAT for every request
//
// Ports:
//   clk             in   1   clock, rising edge
//   rst             in   1   synchronous active-high reset
//   sram_reqValid   in   1   request valid, held by master until response
//   sram_addr       in   32  byte address, bits [1:0] ignored
//   sram_wen        in   1   1 = write, 0 = read
//   sram_wdata      in   32  lane-aligned write data
//   sram_wmask      in   4   byte-lane write enables
//   sram_rdata      out  32  read data, zero outside the response cycle
//   sram_respValid  out  1   one-cycle response pulse
//   sram_err        out  1   out-of-range flag, pulses with sram_respValid
// ----------------------------------------------------------------------------
module ysyx_25070198_sbus_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          FIXED_LAT   = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_reqValid,
    input  logic [31:0] sram_addr,
    input  logic        sram_wen,
    input  logic [31:0] sram_wdata,
    input  logic [3:0]  sram_wmask,
    output logic [31:0] sram_rdata,
    output logic        sram_respValid,
    output logic        sram_err
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LAST = ADDR_BASE + 32'(DEPTH_WORDS) * 32'd4 - 32'd1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, next_state;
    logic [4:0]  cnt_q, cnt_next;
    logic [4:0]  lat;
    logic [31:0] addr_q, wdata_q;
    logic        wen_q;
    logic [3:0]  wmask_q;

    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] offset;
    logic [IDX_W-1:0] idx;
    logic        in_range;
    logic        unused_bits;

    logic [31:0] mem [DEPTH_WORDS];

`ifdef SBUS_RAND_DELAY_EN
    // Latency source: Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting left
    // with the XOR of bits 8,6,5,4 (indices 7,5,4,3) fed into bit 0. It runs
    // every non-reset cycle, so the latency a request gets depends on when it
    // arrives, not only on how many requests came before it.
    logic [7:0] lfsr;
    logic       unused_fixed;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign lat          = {3'b000, lfsr[1:0]} + 5'd1;
    assign unused_fixed = ^FIXED_LAT;
`else
    logic unused_seed;

    assign lat         = 5'(FIXED_LAT);
    assign unused_seed = ^LFSR_SEED;
`endif

    // In IDLE the request is still on the bus. Later the latched copy is the
    // only source. A latency-1 request therefore reads memory straight from
    // the bus inputs on its way into RESP.
    assign req_addr = (state == IDLE) ? sram_addr : addr_q;
    assign req_wen  = (state == IDLE) ? sram_wen  : wen_q;
    assign offset   = req_addr - ADDR_BASE;
    assign idx      = offset[IDX_W+1:2];
    assign in_range = (req_addr >= ADDR_BASE) && (req_addr <= ADDR_LAST);

    assign unused_bits = ^{offset[1:0], offset[31:IDX_W+2]};

    // State register and delay counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= next_state;
            cnt_q <= cnt_next;
        end
    end

    // Next-state logic. The counter is loaded with lat-1 on acceptance.
    // It is then counted down in BUSY, and RESP follows the cycle in which
    // it reads 1. This places the response exactly lat cycles after acceptance.
    always_comb begin
        next_state = state;
        cnt_next   = cnt_q;
        case (state)
            IDLE: begin
                if (sram_reqValid) begin
                    cnt_next   = lat - 5'd1;
                    next_state = (lat == 5'd1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 5'd1) begin
                    next_state = RESP;
                end else begin
                    cnt_next = cnt_q - 5'd1;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture on acceptance. This register is not reset because the
    // FSM only consumes it after a fresh acceptance.
    always_ff @(posedge clk) begin
        if (state == IDLE && sram_reqValid) begin
            addr_q  <= sram_addr;
            wen_q   <= sram_wen;
            wdata_q <= sram_wdata;
            wmask_q <= sram_wmask;
        end
    end

    // Registered response outputs, loaded on entry to RESP and zero otherwise.
    // Writes and out-of-range reads return zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_respValid <= 1'b0;
            sram_err       <= 1'b0;
            sram_rdata     <= '0;
        end else if (next_state == RESP) begin
            sram_respValid <= 1'b1;
            sram_err       <= ~in_range;
            sram_rdata     <= (!req_wen && in_range) ? mem[idx] : '0;
        end else begin
            sram_respValid <= 1'b0;
            sram_err       <= 1'b0;
            sram_rdata     <= '0;
        end
    end

    // Write commit happens at the edge that ends RESP. A reset arriving in
    // RESP therefore cancels it. Contents are intentionally never cleared.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && wen_q && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25070198_sbus_sram.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25070198_sbus_sram
//
// Two instances share clk/rst: instance 0 uses FIXED_LAT=1 and instance 1
// uses FIXED_LAT=3. Transactions are checked against a word-level memory
// model kept in an associative array. The fixed-latency, held-request and
// mid-request reset scenarios only run when SBUS_RAND_DELAY_EN is undefined.
// ----------------------------------------------------------------------------
module tb_ysyx_25070198_sbus_sram;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic [31:0] req_addr  [2];
    logic        req_wen   [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic [31:0] rdata_o   [2];
    logic        resp_valid[2];
    logic        err_o     [2];

    int n_checks;
    int n_fail;
    int exp_lat [2];
    int lat_hist [5];
    logic [31:0] model_mem [int];

    ysyx_25070198_sbus_sram #(
        .ADDR_BASE  (BASE),
        .DEPTH_WORDS(DEPTH),
        .FIXED_LAT  (1),
        .LFSR_SEED  (8'hA5)
    ) dut0 (
        .clk           (clk),
        .rst           (rst),
        .sram_reqValid (req_valid[0]),
        .sram_addr     (req_addr[0]),
        .sram_wen      (req_wen[0]),
        .sram_wdata    (req_wdata[0]),
        .sram_wmask    (req_wmask[0]),
        .sram_rdata    (rdata_o[0]),
        .sram_respValid(resp_valid[0]),
        .sram_err      (err_o[0])
    );

    ysyx_25070198_sbus_sram #(
        .ADDR_BASE  (BASE),
        .DEPTH_WORDS(DEPTH),
        .FIXED_LAT  (3),
        .LFSR_SEED  (8'hA5)
    ) dut1 (
        .clk           (clk),
        .rst           (rst),
        .sram_reqValid (req_valid[1]),
        .sram_addr     (req_addr[1]),
        .sram_wen      (req_wen[1]),
        .sram_wdata    (req_wdata[1]),
        .sram_wmask    (req_wmask[1]),
        .sram_rdata    (rdata_o[1]),
        .sram_respValid(resp_valid[1]),
        .sram_err      (err_o[1])
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request starting at the current negedge. It holds reqValid
    // until the response is seen, and reports the observed latency in cycles.
    task automatic applyStimulus(input int d, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wmask,
                                 output logic [31:0] rdata, output logic err, output int lat);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        req_wen[d]   = wen;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid[d]) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            checkOutput("resp_timeout", 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            @(negedge clk);
            return;
        end
        rdata = rdata_o[d];
        err   = err_o[d];
        req_valid[d] = 1'b0;
        @(negedge clk);
        checkOutput("pulse_width", 32'(resp_valid[d]), 32'd0);
        checkOutput("rdata_idle", rdata_o[d], 32'd0);
    endtask

    // One transaction checked against the word-level model
    task automatic runTxn(input int d, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          output logic [31:0] rdata, output logic err);
        longint unsigned a;
        logic            in_rng;
        int              key;
        int              lat;
        logic [31:0]     bm;
        a      = 64'(addr);
        in_rng = (a >= 64'(BASE)) && (a < 64'(BASE) + 64'(4 * DEPTH));
        key    = in_rng ? d * DEPTH + int'((a - 64'(BASE)) / 4) : -1;
        applyStimulus(d, wen, addr, wdata, wmask, rdata, err, lat);
        if (lat == 0) return;
`ifdef SBUS_RAND_DELAY_EN
        checkOutput("lat_range", 32'(lat >= 1 && lat <= 4), 32'd1);
        if (lat >= 1 && lat <= 4) lat_hist[lat]++;
`else
        checkOutput("latency", 32'(lat), 32'(exp_lat[d]));
`endif
        checkOutput("err", 32'(err), 32'(!in_rng));
        if (wen) begin
            checkOutput("wr_rdata", rdata, 32'd0);
            if (in_rng) begin
                bm = '0;
                for (int b = 0; b < 4; b++) if (wmask[b]) bm[b*8 +: 8] = 8'hFF;
                if (model_mem.exists(key))
                    model_mem[key] = (model_mem[key] & ~bm) | (wdata & bm);
                else if (bm == 32'hFFFF_FFFF)
                    model_mem[key] = wdata;
            end
        end else if (!in_rng) begin
            checkOutput("oor_rdata", rdata, 32'd0);
        end else if (model_mem.exists(key)) begin
            checkOutput("rd_data", rdata, model_mem[key]);
        end
    endtask

    // Random traffic over a 17-word window (words 0..15 and the last word)
    // plus addresses just below and just above the mapped range
    task automatic randomRun(input int d, input int count);
        logic [31:0] rd, addr;
        logic        er;
        int          pick, word;
        for (int w = 0; w <= 16; w++) begin
            word = (w == 16) ? DEPTH - 1 : w;
            runTxn(d, 1'b1, BASE + 32'(word * 4), $urandom, 4'hF, rd, er);
        end
        for (int i = 0; i < count; i++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
                addr = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            end else if (pick == 1) begin
                addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            end else begin
                word = $urandom_range(0, 16);
                if (word == 16) word = DEPTH - 1;
                addr = BASE + 32'(word * 4) + 32'($urandom_range(0, 3));
            end
            runTxn(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), rd, er);
        end
    endtask

    // Main sequence
    initial begin
        logic [31:0] rd;
        logic        er;
        n_checks   = 0;
        n_fail     = 0;
        exp_lat[0] = 1;
        exp_lat[1] = 3;
        for (int l = 0; l < 5; l++) lat_hist[l] = 0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            req_wen[d]   = 1'b0;
            req_wdata[d] = '0;
            req_wmask[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_resp", 32'(resp_valid[d]), 32'd0);
            checkOutput("rst_rdata", rdata_o[d], 32'd0);
            checkOutput("rst_err", 32'(err_o[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Write then read back
        runTxn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er);
        runTxn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er);
        checkOutput("wr_rd_data", rd, 32'hDEAD_BEEF);
        checkOutput("wr_rd_err", 32'(er), 32'd0);

        // Byte mask merge
        runTxn(0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er);
        runTxn(0, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, rd, er);
        runTxn(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er);
        checkOutput("mask_data", rd, 32'h11BB_33DD);

        // Empty mask changes nothing
        runTxn(0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, rd, er);
        runTxn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er);
        checkOutput("zero_mask", rd, 32'hDEAD_BEEF);

        // Out of range on both sides, and the last in-range word
        runTxn(0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, rd, er);
        runTxn(0, 1'b1, 32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF, rd, er);
        runTxn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er);
        checkOutput("oor_low_err", 32'(er), 32'd1);
        checkOutput("oor_low_data", rd, 32'd0);
        runTxn(0, 1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, rd, er);
        checkOutput("oor_high_err", 32'(er), 32'd1);
        runTxn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er);
        checkOutput("oor_no_alias", rd, 32'hCAFE_F00D);
        runTxn(0, 1'b0, 32'h8000_3FFC, 32'h0, 4'h0, rd, er);
        checkOutput("last_word", rd, 32'h0BAD_CAFE);
        checkOutput("last_word_err", 32'(er), 32'd0);

`ifndef SBUS_RAND_DELAY_EN
        // Request held high across two transactions on the latency-3 instance.
        // Responses are expected at T+3 and T+7.
        runTxn(1, 1'b1, 32'h8000_0008, 32'h5A5A_A5A5, 4'hF, rd, er);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0008;
        req_wen[1]   = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checkOutput($sformatf("held_resp_T%0d", n), 32'(resp_valid[1]), 32'(n == 3 || n == 7));
            if (n == 3 || n == 7) checkOutput("held_rdata", rdata_o[1], 32'h5A5A_A5A5);
        end
        req_valid[1] = 1'b0;
        @(negedge clk);

        // Reset during BUSY discards the pending write
        runTxn(1, 1'b1, 32'h8000_0040, 32'h0, 4'hF, rd, er);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0040;
        req_wen[1]   = 1'b1;
        req_wdata[1] = 32'h0000_0055;
        req_wmask[1] = 4'hF;
        @(negedge clk);
        rst          = 1'b1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            checkOutput("rst_busy_resp", 32'(resp_valid[1]), 32'd0);
            @(negedge clk);
        end
        runTxn(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er);
        checkOutput("rst_busy_data", rd, 32'd0);

        randomRun(0, 300);
        randomRun(1, 300);
`else
        randomRun(0, 1000);
        for (int l = 1; l <= 4; l++)
            checkOutput($sformatf("lat_seen_%0d", l), 32'(lat_hist[l] > 0), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
